// File: rtl/clkgen_multi.sv
// clkgen_multi: NCH-channel programmable clock divider.
// Each channel toggles its output every HALF enabled clkin cycles. HALF is
// double-buffered (shadow -> active) and only swapped at a toggle boundary,
// so an output half-period is never cut short.
// Ports:
//   i_clkin      board clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clken      global count enable
//   i_ch_en      per-channel count enable
//   i_wr_en      half-period write strobe
//   i_wr_ch      write target channel (>= NCH ignored)
//   i_wr_half    new half-period, 0 stops the channel
//   i_sync_clr   restart all channels in phase
//   o_clkout     divided clocks
//   o_tick       one-cycle pulse on each clkout rising edge
//   o_pending    shadow written but not yet applied

// One divider channel.
module clkgen_ch #(
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 25000
) (
    input  logic             i_clkin,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_half,
    input  logic             i_sync_clr,
    output logic             o_clkout,
    output logic             o_tick,
    output logic             o_pending
);
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic             r_pending;

    logic w_stopped;
    logic w_bnd;

    assign w_stopped = (r_active == '0);
    // cnt never exceeds active-1, so this compare cannot be skipped over
    assign w_bnd     = (r_cnt == r_active - CNT_W'(1));

    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow  <= RST_HALF;
            r_active  <= RST_HALF;
            r_cnt     <= '0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_sync_clr) begin
                // a same-cycle write beats any older pending shadow value
                r_cnt     <= '0;
                r_clk     <= 1'b0;
                r_pending <= 1'b0;
                if (i_wr) begin
                    r_active <= i_wr_half;
                    r_shadow <= i_wr_half;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
            end else if (w_stopped) begin
                // stopped channel: a write restarts it at once, keeping the
                // current output level; otherwise the output is parked low
                r_cnt <= '0;
                if (i_wr) begin
                    r_active  <= i_wr_half;
                    r_shadow  <= i_wr_half;
                    r_pending <= 1'b0;
                end else begin
                    r_clk <= 1'b0;
                end
            end else if (i_en && w_bnd) begin
                r_cnt  <= '0;
                r_clk  <= ~r_clk;
                r_tick <= ~r_clk;
                if (i_wr) begin
                    r_active  <= i_wr_half;
                    r_shadow  <= i_wr_half;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else begin
                if (i_en) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (i_wr) begin
                    r_shadow  <= i_wr_half;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign o_clkout  = r_clk;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;
endmodule

module clkgen_multi #(
    parameter int NCH          = 4,
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 25000,
    localparam int WCH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             i_clkin,
    input  logic             i_rst_n,
    input  logic             i_clken,
    input  logic [NCH-1:0]   i_ch_en,
    input  logic             i_wr_en,
    input  logic [WCH_W-1:0] i_wr_ch,
    input  logic [CNT_W-1:0] i_wr_half,
    input  logic             i_sync_clr,
    output logic [NCH-1:0]   o_clkout,
    output logic [NCH-1:0]   o_tick,
    output logic [NCH-1:0]   o_pending
);
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic w_wr;
        logic w_en;

        // channel numbers >= NCH match no instance, so such writes drop out
        assign w_wr = i_wr_en && (i_wr_ch == WCH_W'(g));
        assign w_en = i_clken && i_ch_en[g];

        clkgen_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .i_clkin    (i_clkin),
            .i_rst_n    (i_rst_n),
            .i_en       (w_en),
            .i_wr       (w_wr),
            .i_wr_half  (i_wr_half),
            .i_sync_clr (i_sync_clr),
            .o_clkout   (o_clkout[g]),
            .o_tick     (o_tick[g]),
            .o_pending  (o_pending[g])
        );
    end
endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi: directed scenarios plus a randomized run, all
// checked against a countdown model of each channel.
module tb_clkgen_multi;
    localparam int NCH = 3;
    localparam int CNT_W = 8;
    localparam int DH = 4;
    localparam int WCH_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clken;
    logic [NCH-1:0]   ch_en;
    logic             wr_en;
    logic [WCH_W-1:0] wr_ch;
    logic [CNT_W-1:0] wr_half;
    logic             sync_clr;
    logic [NCH-1:0]   o_clkout;
    logic [NCH-1:0]   o_tick;
    logic [NCH-1:0]   o_pending;

    int n_chk = 0;
    int n_fail = 0;

    // model: level, cycles left until next toggle, current half, queued half
    int m_lvl[NCH];
    int m_tick[NCH];
    int m_left[NCH];
    int m_cur[NCH];
    int m_nxt[NCH];
    int m_has[NCH];

    clkgen_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_HALF(DH)) dut (
        .i_clkin    (clk),
        .i_rst_n    (rst_n),
        .i_clken    (clken),
        .i_ch_en    (ch_en),
        .i_wr_en    (wr_en),
        .i_wr_ch    (wr_ch),
        .i_wr_half  (wr_half),
        .i_sync_clr (sync_clr),
        .o_clkout   (o_clkout),
        .o_tick     (o_tick),
        .o_pending  (o_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] mv_clk();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_lvl[i][0];
        return v;
    endfunction

    function automatic logic [NCH-1:0] mv_tick();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_tick[i][0];
        return v;
    endfunction

    function automatic logic [NCH-1:0] mv_pend();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_has[i][0];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_lvl[i] = 0; m_tick[i] = 0; m_cur[i] = DH; m_left[i] = DH;
            m_nxt[i] = 0; m_has[i] = 0;
        end
    endtask

    // one clkin rising edge worth of behaviour, from the inputs as driven
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            bit wr, en;
            int d;
            wr = wr_en && (int'(wr_ch) == i);
            en = clken && ch_en[i];
            d = int'(wr_half);
            m_tick[i] = 0;
            if (sync_clr) begin
                m_lvl[i] = 0;
                if (wr) m_cur[i] = d;
                else if (m_has[i] != 0) m_cur[i] = m_nxt[i];
                m_has[i] = 0;
                m_left[i] = m_cur[i];
            end else if (m_cur[i] == 0) begin
                if (wr) begin
                    m_cur[i] = d; m_left[i] = d; m_has[i] = 0;
                end else begin
                    m_lvl[i] = 0;
                end
            end else if (en && m_left[i] == 1) begin
                m_lvl[i] = 1 - m_lvl[i];
                m_tick[i] = m_lvl[i];
                if (wr) m_cur[i] = d;
                else if (m_has[i] != 0) m_cur[i] = m_nxt[i];
                m_has[i] = 0;
                m_left[i] = m_cur[i];
            end else begin
                if (en) m_left[i] = m_left[i] - 1;
                if (wr) begin
                    m_nxt[i] = d; m_has[i] = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clken = 1'b0; ch_en = '0; wr_en = 1'b0; wr_ch = '0;
        wr_half = '0; sync_clr = 1'b0;
        model_reset();
        #2;
        n_chk++;
        if (o_clkout !== 3'b000) begin
            n_fail++; $display("FAIL reset_clkout got=%b exp=000", o_clkout);
        end
        n_chk++;
        if (o_tick !== 3'b000) begin
            n_fail++; $display("FAIL reset_tick got=%b exp=000", o_tick);
        end
        n_chk++;
        if (o_pending !== 3'b000) begin
            n_fail++; $display("FAIL reset_pending got=%b exp=000", o_pending);
        end
    endtask

    task automatic test_default();
        clken = 1'b1; ch_en = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            n_chk++;
            if (o_clkout[0] !== ((c >= 4 && c < 8) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL default_clk cyc=%0d got=%b", c, o_clkout[0]);
            end
            n_chk++;
            if (o_tick[0] !== ((c == 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL default_tick cyc=%0d got=%b", c, o_tick[0]);
            end
            n_chk++;
            if (o_clkout !== mv_clk()) begin
                n_fail++; $display("FAIL default_model got=%b exp=%b", o_clkout, mv_clk());
            end
        end
    endtask

    task automatic test_pending();
        bit exp_clk[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        wr_en = 1'b1; wr_ch = 2'd1; wr_half = 8'd5; sync_clr = 1'b1;
        step();
        wr_en = 1'b0; sync_clr = 1'b0;
        n_chk++;
        if (o_clkout !== 3'b000) begin
            n_fail++; $display("FAIL pend_sync clkout got=%b exp=000", o_clkout);
        end
        step(); step();
        wr_en = 1'b1; wr_ch = 2'd1; wr_half = 8'd2;
        step();
        wr_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if (o_pending[1] !== 1'b1 || o_clkout[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL pend_hold cyc=%0d pend=%b clk=%b exp pend=1 clk=0", c, o_pending[1], o_clkout[1]);
            end
            if (c == 0) step();
        end
        // 5th edge after the sync is the boundary, then 2-cycle halves
        for (int c = 0; c < 5; c++) begin
            step();
            n_chk++;
            if (o_clkout[1] !== exp_clk[c] || o_pending[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL pend_apply cyc=%0d clk=%b pend=%b exp clk=%b pend=0", c, o_clkout[1], o_pending[1], exp_clk[c]);
            end
            n_chk++;
            if (o_clkout !== mv_clk() || o_tick !== mv_tick()) begin
                n_fail++;
                $display("FAIL pend_model clk=%b tick=%b exp clk=%b tick=%b", o_clkout, o_tick, mv_clk(), mv_tick());
            end
        end
    endtask

    task automatic test_stop();
        int guard = 0;
        wr_en = 1'b1; wr_ch = 2'd2; wr_half = 8'd0;
        step();
        wr_en = 1'b0;
        while (m_has[2] != 0 && guard < 12) begin
            n_chk++;
            if (o_pending[2] !== 1'b1) begin
                n_fail++; $display("FAIL stop_pending got=%b exp=1", o_pending[2]);
            end
            step();
            guard++;
        end
        if (guard >= 12) begin
            n_fail++; $display("FAIL stop_timeout pending never cleared in model");
        end
        step(); step();
        for (int c = 0; c < 20; c++) begin
            n_chk++;
            if (o_clkout[2] !== 1'b0 || o_tick[2] !== 1'b0) begin
                n_fail++; $display("FAIL stop_low cyc=%0d clk=%b tick=%b exp 0", c, o_clkout[2], o_tick[2]);
            end
            step();
        end
        wr_en = 1'b1; wr_ch = 2'd2; wr_half = 8'd3;
        step();
        wr_en = 1'b0;
        n_chk++;
        if (o_clkout[2] !== 1'b0 || o_pending[2] !== 1'b0) begin
            n_fail++; $display("FAIL stop_restart clk=%b pend=%b exp 0 0", o_clkout[2], o_pending[2]);
        end
        step(); step();
        n_chk++;
        if (o_clkout[2] !== 1'b0) begin
            n_fail++; $display("FAIL stop_early got=%b exp=0", o_clkout[2]);
        end
        step();
        n_chk++;
        if (o_clkout[2] !== 1'b1 || o_tick[2] !== 1'b1) begin
            n_fail++; $display("FAIL stop_rise clk=%b tick=%b exp 1 1", o_clkout[2], o_tick[2]);
        end
    endtask

    task automatic test_freeze();
        int rem, lvl;
        logic [NCH-1:0] snap;
        int pre = $urandom_range(1, 3);
        for (int c = 0; c < pre; c++) step();
        rem = m_left[0]; lvl = m_lvl[0]; snap = o_clkout;
        clken = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_chk++;
            if (o_clkout !== snap || o_tick !== 3'b000) begin
                n_fail++; $display("FAIL freeze_hold cyc=%0d clk=%b tick=%b exp clk=%b tick=000", c, o_clkout, o_tick, snap);
            end
        end
        clken = 1'b1;
        for (int k = 1; k <= rem; k++) begin
            step();
            n_chk++;
            if (o_clkout[0] !== ((k == rem) ? ~lvl[0] : lvl[0])) begin
                n_fail++; $display("FAIL freeze_resume k=%0d rem=%0d got=%b", k, rem, o_clkout[0]);
            end
        end
    endtask

    task automatic test_sync();
        int first0 = -1, first1 = -1, both = 0;
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 8'd3;
        step();
        wr_ch = 2'd1; wr_half = 8'd5;
        step();
        wr_en = 1'b0; sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        n_chk++;
        if (o_clkout[1:0] !== 2'b00 || o_pending !== 3'b000) begin
            n_fail++; $display("FAIL sync_clear clk=%b pend=%b exp clk=00 pend=000", o_clkout[1:0], o_pending);
        end
        for (int c = 1; c <= 60; c++) begin
            step();
            if (o_tick[0] && first0 < 0) first0 = c;
            if (o_tick[1] && first1 < 0) first1 = c;
            if (o_tick[0] && o_tick[1]) both++;
            n_chk++;
            if (o_clkout !== mv_clk() || o_tick !== mv_tick()) begin
                n_fail++; $display("FAIL sync_model cyc=%0d clk=%b tick=%b exp clk=%b tick=%b", c, o_clkout, o_tick, mv_clk(), mv_tick());
            end
        end
        n_chk++;
        if (first0 != 3 || first1 != 5) begin
            n_fail++; $display("FAIL sync_first rise0=%0d rise1=%0d exp 3 5", first0, first1);
        end
        n_chk++;
        if (both != 2) begin
            n_fail++; $display("FAIL sync_coincide got=%0d exp=2", both);
        end
    endtask

    task automatic test_boundary();
        int guard = 0;
        logic lvl;
        while (m_left[0] != 1 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) begin
            n_fail++; $display("FAIL bnd_timeout boundary not reached");
        end
        lvl = o_clkout[0];
        wr_en = 1'b1; wr_ch = 2'd0; wr_half = 8'd2;
        step();
        wr_en = 1'b0;
        n_chk++;
        if (o_pending[0] !== 1'b0 || o_clkout[0] !== ~lvl) begin
            n_fail++; $display("FAIL bnd_write pend=%b clk=%b exp pend=0 clk=%b", o_pending[0], o_clkout[0], ~lvl);
        end
        step();
        n_chk++;
        if (o_clkout[0] !== ~lvl) begin
            n_fail++; $display("FAIL bnd_half1 got=%b exp=%b", o_clkout[0], ~lvl);
        end
        step();
        n_chk++;
        if (o_clkout[0] !== lvl) begin
            n_fail++; $display("FAIL bnd_half2 got=%b exp=%b", o_clkout[0], lvl);
        end
        // run until channel 0 is high, then pull reset between edges
        guard = 0;
        while (o_clkout[0] !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (o_clkout !== 3'b000 || o_tick !== 3'b000 || o_pending !== 3'b000) begin
            n_fail++; $display("FAIL async_reset clk=%b tick=%b pend=%b exp all 0", o_clkout, o_tick, o_pending);
        end
        model_reset();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clken    = ($urandom % 8) != 0;
            ch_en    = NCH'($urandom | $urandom);
            wr_en    = ($urandom % 4) == 0;
            wr_ch    = WCH_W'($urandom % 4);
            wr_half  = CNT_W'($urandom_range(0, 6));
            sync_clr = ($urandom % 40) == 0;
            step();
            n_chk++;
            if (o_clkout !== mv_clk()) begin
                n_fail++; $display("FAIL rand_clk cyc=%0d got=%b exp=%b", c, o_clkout, mv_clk());
            end
            n_chk++;
            if (o_tick !== mv_tick()) begin
                n_fail++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", c, o_tick, mv_tick());
            end
            n_chk++;
            if (o_pending !== mv_pend()) begin
                n_fail++; $display("FAIL rand_pend cyc=%0d got=%b exp=%b", c, o_pending, mv_pend());
            end
        end
        wr_en = 1'b0; sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_pending();
        test_stop();
        test_freeze();
        test_sync();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
